bus_timer: RTL and testbench



---
 rtl/bus_timer_pkg.sv | 19 +
 rtl/bus_target_decode.sv | 33 +++
 rtl/bus_timer.sv | 122 ++++++++++++
 tb/tb_bus_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register offsets, CTRL bit positions and the register word type
// shared by the bus timer and its bus decoder.
// Latency: n/a (types and constants only). Backpressure: n/a.
package bus_timer_pkg;

  typedef logic [15:0] reg16_t;

  // Word offsets within the 4-word register window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_RELOAD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit positions
  localparam int EN_B   = 0;
  localparam int AUTO_B = 1;
  localparam int IE_B   = 2;

endpackage

// File: rtl/bus_target_decode.sv
// bus_target_decode: address/strobe decode for a 4-word bus target window at BASE.
// Latency: purely combinational. Backpressure: none, the bus has no wait states.
// Ports: BUS_A/BUS_R/BUS_W in; hit, rd_en, wr_en and a one-hot register select out.
//   rd_en and wr_en are qualified so that a cycle with both strobes high does neither.
module bus_target_decode
  import bus_timer_pkg::*;
#(
  parameter logic [22:0] BASE = 23'h7F_FFF0
) (
  input  logic [22:0] BUS_A,
  input  logic        BUS_R,
  input  logic        BUS_W,
  output logic        hit,
  output logic        rd_en,
  output logic        wr_en,
  output logic [3:0]  sel
);

  assign hit   = (BUS_A[22:2] == BASE[22:2]);
  assign rd_en = hit & BUS_R & ~BUS_W;
  assign wr_en = hit & BUS_W & ~BUS_R;

  always_comb begin
    sel = 4'b0000;
    unique case (BUS_A[1:0])
      OFF_CTRL:   sel[0] = 1'b1;
      OFF_RELOAD: sel[1] = 1'b1;
      OFF_COUNT:  sel[2] = 1'b1;
      default:    sel[3] = 1'b1;
    endcase
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit down-counting timer with level interrupt PIC_I.
// Latency: reads combinational, writes take effect at the edge, PIC_I lags PEND/IE by 1 cycle.
// Backpressure: none; a cycle with BUS_R and BUS_W both high is ignored.
// Ports: _CLK clock, RST sync active-high reset, BUS_A/BUS_D/BUS_R/BUS_W target bus,
//   PIC_I interrupt request. Optional macro BUS_TIMER_PRESCALE_EN adds CTRL[15:8] PRE,
//   giving one count tick every PRE+1 cycles.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [22:0] BASE         = 23'h7F_FFF0,
  parameter logic [15:0] RESET_RELOAD = 16'h0000
) (
  input  logic        _CLK,
  input  logic        RST,
  input  logic [22:0] BUS_A,
  inout  wire  [15:0] BUS_D,
  input  logic        BUS_R,
  input  logic        BUS_W,
  output logic        PIC_I
);

  logic       hit, rd_en, wr_en;
  logic [3:0] sel;

  bus_target_decode #(.BASE(BASE)) u_decode (
    .BUS_A (BUS_A),
    .BUS_R (BUS_R),
    .BUS_W (BUS_W),
    .hit   (hit),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .sel   (sel)
  );

  reg16_t count_q, reload_q;
  logic   en_q, auto_q, ie_q, pend_q;
  reg16_t wr_dat, rd_dat, ctrl_rd;
  logic   wr_ctrl, wr_reload, wr_count, wr_status;
  logic   tick, underflow;

  assign wr_dat    = BUS_D;
  assign wr_ctrl   = wr_en & sel[OFF_CTRL];
  assign wr_reload = wr_en & sel[OFF_RELOAD];
  assign wr_count  = wr_en & sel[OFF_COUNT];
  assign wr_status = wr_en & sel[OFF_STATUS];

`ifdef BUS_TIMER_PRESCALE_EN
  logic [7:0] pre_q, psc_q;

  assign tick    = (psc_q == pre_q);
  assign ctrl_rd = {pre_q, 5'b0, ie_q, auto_q, en_q};

  // Prescaler phase: held at 0 while stopped so the first tick after enabling
  // lands a full PRE+1 cycles later; a CTRL write also restarts the phase.
  always_ff @(posedge _CLK) begin
    if (RST) begin
      pre_q <= 8'd0;
      psc_q <= 8'd0;
    end else begin
      if (wr_ctrl) pre_q <= wr_dat[15:8];
      if (wr_ctrl || !en_q || tick) psc_q <= 8'd0;
      else                          psc_q <= psc_q + 8'd1;
    end
  end
`else
  assign tick    = 1'b1;
  assign ctrl_rd = {13'b0, ie_q, auto_q, en_q};
`endif

  // Underflow fires one tick after COUNT reached zero, hence RELOAD+1 ticks per period.
  assign underflow = tick & en_q & (count_q == 16'd0);

  always_ff @(posedge _CLK) begin
    if (RST) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      count_q  <= 16'd0;
      reload_q <= RESET_RELOAD;
      pend_q   <= 1'b0;
      PIC_I    <= 1'b0;
    end else begin
      PIC_I <= pend_q & ie_q;

      // A CTRL write wins over the one-shot hardware clear of EN.
      if (wr_ctrl) begin
        en_q   <= wr_dat[EN_B];
        auto_q <= wr_dat[AUTO_B];
        ie_q   <= wr_dat[IE_B];
      end else if (underflow && !auto_q) begin
        en_q <= 1'b0;
      end

      if (wr_reload) reload_q <= wr_dat;

      // A COUNT write wins over decrement/reload; one-shot parks at zero.
      if (wr_count) begin
        count_q <= wr_dat;
      end else if (tick && en_q) begin
        if (count_q == 16'd0) count_q <= auto_q ? reload_q : 16'd0;
        else                  count_q <= count_q - 16'd1;
      end

      // Set wins over a same-edge W1C so an underflow is never dropped.
      if (underflow)                   pend_q <= 1'b1;
      else if (wr_status && wr_dat[0]) pend_q <= 1'b0;
    end
  end

  always_comb begin
    rd_dat = 16'd0;
    unique case (BUS_A[1:0])
      OFF_CTRL:   rd_dat = ctrl_rd;
      OFF_RELOAD: rd_dat = reload_q;
      OFF_COUNT:  rd_dat = count_q;
      default:    rd_dat = {15'b0, pend_q};
    endcase
  end

  assign BUS_D = rd_en ? rd_dat : 16'hzzzz;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed plus randomized bus traffic against a behavioural timer model.
// Latency: n/a. Backpressure: n/a.
// The bus carries a weak pull-up, so an undriven BUS_D is observed as 16'hFFFF.
module tb_bus_timer;

  localparam logic [22:0] BASE = 23'h7F_FFF0;
  localparam logic [15:0] RRL  = 16'h00A5;
`ifdef BUS_TIMER_PRESCALE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [22:0] BUS_A = '0;
  logic        BUS_R = 1'b0;
  logic        BUS_W = 1'b0;
  wire  [15:0] BUS_D;
  logic        PIC_I;
  logic [15:0] tb_drv = '0;
  logic        tb_drv_en = 1'b0;
  bit          checking = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  assign BUS_D = tb_drv_en ? tb_drv : 16'hzzzz;
  pullup (BUS_D);

  always #5 clk = ~clk;

  bus_timer #(.BASE(BASE), .RESET_RELOAD(RRL)) dut (
    ._CLK  (clk),
    .RST   (RST),
    .BUS_A (BUS_A),
    .BUS_D (BUS_D),
    .BUS_R (BUS_R),
    .BUS_W (BUS_W),
    .PIC_I (PIC_I)
  );

  // ---------------- behavioural model ----------------
  bit      m_en, m_auto, m_ie, m_pend, m_pic;
  int      m_count, m_reload, m_pre, m_phase;

  function automatic logic [15:0] mread(input int off);
    case (off)
      0:       return {PRE ? 8'(m_pre) : 8'd0, 5'd0, m_ie, m_auto, m_en};
      1:       return 16'(m_reload);
      2:       return 16'(m_count);
      default: return {15'd0, m_pend};
    endcase
  endfunction

  always @(posedge clk) begin
    bit hit, wr, tick, fire, ne;
    int off, nc;
    hit = (BUS_A[22:2] == BASE[22:2]);
    off = int'(BUS_A[1:0]);
    wr  = hit && BUS_W && !BUS_R;
    if (RST) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_pic = 0;
      m_count = 0; m_reload = int'(RRL); m_pre = 0; m_phase = 0;
    end else begin
      m_pic = m_pend && m_ie;
      // one tick per (PRE+1) cycles of an enabled, undisturbed run
      tick  = PRE ? (m_phase == m_pre) : 1'b1;
      fire  = tick && m_en && (m_count == 0);
      if (PRE) m_phase = ((wr && off == 0) || !m_en || tick) ? 0 : m_phase + 1;
      nc = m_count;
      ne = m_en;
      if (tick && m_en) begin
        if (m_count == 0) begin
          nc = m_auto ? m_reload : 0;
          ne = m_auto;
        end else begin
          nc = m_count - 1;
        end
      end
      if (fire) m_pend = 1;
      else if (wr && off == 3 && tb_drv[0]) m_pend = 0;
      if (wr) begin
        case (off)
          0: begin
            ne = tb_drv[0]; m_auto = tb_drv[1]; m_ie = tb_drv[2];
            if (PRE) m_pre = int'(tb_drv[15:8]);
          end
          1: m_reload = int'(tb_drv);
          2: nc = int'(tb_drv);
          default: ;
        endcase
      end
      m_count = nc;
      m_en    = ne;
    end
  end

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %04h expected %04h at %0t", nm, act, exp, $time);
  endfunction

  // every-cycle compare against the model
  always @(negedge clk) begin
    logic [15:0] exp_d;
    if (checking) begin
      if ((BUS_A[22:2] == BASE[22:2]) && BUS_R && !BUS_W) exp_d = mread(int'(BUS_A[1:0]));
      else if (tb_drv_en)                                 exp_d = tb_drv;
      else                                                exp_d = 16'hFFFF;
      chk("bus_d", BUS_D, exp_d);
      chk("pic_i", {15'd0, PIC_I}, {15'd0, m_pic});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [22:0] a, input logic r, input logic w,
                       input logic [15:0] d, input logic rst);
    @(posedge clk);
    #2;
    BUS_A = a; BUS_R = r; BUS_W = w; tb_drv = d; tb_drv_en = w; RST = rst;
  endtask

  task automatic idle();
    drive(23'd0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] off, input logic [15:0] d);
    drive(BASE + 23'(off), 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] off, input logic [15:0] exp);
    drive(BASE + 23'(off), 1'b1, 1'b0, 16'd0, 1'b0);
    #1;
    chk(nm, BUS_D, exp);
  endtask

  initial begin
    drive(23'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    checking = 1'b1;
    drive(23'd0, 1'b0, 1'b0, 16'd0, 1'b1);

    // reset values
    rd_chk("rst_ctrl",   2'd0, 16'h0000);
    rd_chk("rst_reload", 2'd1, RRL);
    rd_chk("rst_count",  2'd2, 16'h0000);
    rd_chk("rst_status", 2'd3, 16'h0000);
    chk("rst_pic", {15'd0, PIC_I}, 16'd0);
    idle(); #1;
    chk("idle_float", BUS_D, 16'hFFFF);

    // one-shot: COUNT=3 -> PEND on 4th edge after CTRL write
    wr(2'd1, 16'd5);
    wr(2'd2, 16'd3);
    wr(2'd0, 16'h0005);
    idle(); idle(); idle();
    rd_chk("os_pend_early", 2'd3, 16'h0000);
    rd_chk("os_pend", 2'd3, 16'h0001);
    chk("os_pic_lag", {15'd0, PIC_I}, 16'd0);
    rd_chk("os_ctrl", 2'd0, 16'h0004);
    chk("os_pic", {15'd0, PIC_I}, 16'd1);
    rd_chk("os_count", 2'd2, 16'h0000);

    // W1C drops PEND, PIC_I follows a cycle later
    wr(2'd3, 16'h0001);
    rd_chk("w1c_pend", 2'd3, 16'h0000);
    chk("w1c_pic_lag", {15'd0, PIC_I}, 16'd1);
    idle(); #1;
    chk("w1c_pic", {15'd0, PIC_I}, 16'd0);

    // auto-reload, period 3; W1C colliding with underflow loses
    wr(2'd2, 16'd2);
    wr(2'd1, 16'd2);
    wr(2'd0, 16'h0007);
    idle(); idle();
    rd_chk("ar_pend_early", 2'd3, 16'h0000);
    rd_chk("ar_pend", 2'd3, 16'h0001);
    wr(2'd3, 16'h0001);
    wr(2'd3, 16'h0001);
    rd_chk("ar_w1c_collide", 2'd3, 16'h0001);
    // COUNT write beats the decrement on the same edge
    wr(2'd2, 16'h00FF);
    rd_chk("cnt_wr_prio", 2'd2, 16'h00FF);

    // reset mid-count with PIC_I high
    drive(23'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    rd_chk("mid_rst_ctrl", 2'd0, 16'h0000);
    chk("mid_rst_pic", {15'd0, PIC_I}, 16'd0);
    rd_chk("mid_rst_reload", 2'd1, RRL);

    // illegal read+write and out-of-window access
    wr(2'd2, 16'h0042);
    drive(BASE + 23'd2, 1'b1, 1'b1, 16'h1234, 1'b0);
    rd_chk("illegal_nowrite", 2'd2, 16'h0042);
    tb_drv_en = 1'b0;
    drive(BASE + 23'd2, 1'b1, 1'b1, 16'h0000, 1'b0);
    tb_drv_en = 1'b0;
    #1;
    chk("illegal_nodrive", BUS_D, 16'hFFFF);
    drive(BASE + 23'd4, 1'b1, 1'b0, 16'h0000, 1'b0); #1;
    chk("out_of_window", BUS_D, 16'hFFFF);

    // prescaler
    wr(2'd2, 16'd1);
    wr(2'd0, 16'h0301);
`ifdef BUS_TIMER_PRESCALE_EN
    rd_chk("pre_ctrl", 2'd0, 16'h0301);
    repeat (6) idle();
    rd_chk("pre_pend_early", 2'd3, 16'h0000);
    rd_chk("pre_pend", 2'd3, 16'h0001);
`else
    rd_chk("pre_ctrl", 2'd0, 16'h0001);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int          op;
      logic [1:0]  off;
      logic [22:0] a;
      logic [15:0] d;
      op  = int'($urandom_range(0, 99));
      off = 2'($urandom_range(0, 3));
      a   = ($urandom_range(0, 9) == 0) ? BASE + 23'd4 : BASE + 23'(off);
      case (off)
        2'd0:    d = {8'($urandom_range(0, 3)), 8'($urandom)};
        2'd3:    d = 16'($urandom);
        default: d = 16'($urandom_range(0, 12));
      endcase
      if ($urandom_range(0, 299) == 0) drive(23'd0, 1'b0, 1'b0, 16'd0, 1'b1);
      else if (op < 35) drive(23'($urandom), 1'b0, 1'b0, 16'd0, 1'b0);
      else if (op < 60) drive(a, 1'b1, 1'b0, 16'd0, 1'b0);
      else if (op < 95) drive(a, 1'b0, 1'b1, d, 1'b0);
      else              drive(a, 1'b1, 1'b1, d, 1'b0);
    end
    idle();
    idle();
    checking = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
